// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common command bytes
// and the odd-parity helper used by the host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Odd parity: the bit that makes the total count of ones in data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin with a one-cycle falling-edge pulse.
// Flops reset high to match an idle, released open-collector line.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_sync,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, shifts one command byte
// out on device clock edges, checks the device ack and reports done/error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                                    TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES);
  localparam logic [CW-1:0] INH_DAT  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYCLES);

  ps2_tx_state_e r_state;
  ps2_tx_state_e w_state_nx;

  logic [7:0]    r_data;
  logic [7:0]    w_data_nx;
  logic          r_par;
  logic          w_par_nx;
  logic [3:0]    r_bit;
  logic [3:0]    w_bit_nx;
  logic [3:0]    w_bit_inc;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic          r_clk_oe;
  logic          w_clk_oe_nx;
  logic          r_dat_oe;
  logic          w_dat_oe_nx;
  logic          r_done;
  logic          w_done_nx;
  logic          r_error;
  logic          w_error_nx;
  logic          w_timeout;
  logic          w_abort;

  logic          w_clk_sync;
  logic          w_clk_fall;
  logic          w_dat_sync;
  logic          w_dat_fall_unused;

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (ps2_clk_in),
    .o_sync (w_clk_sync),
    .o_fall (w_clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (ps2_dat_in),
    .o_sync (w_dat_sync),
    .o_fall (w_dat_fall_unused)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_data   <= w_data_nx;
      r_par    <= w_par_nx;
      r_bit    <= w_bit_nx;
      r_cnt    <= w_cnt_nx;
      r_clk_oe <= w_clk_oe_nx;
      r_dat_oe <= w_dat_oe_nx;
      r_done   <= w_done_nx;
      r_error  <= w_error_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_data_nx   = r_data;
    w_par_nx    = r_par;
    w_bit_nx    = r_bit;
    w_cnt_nx    = r_cnt;
    w_clk_oe_nx = r_clk_oe;
    w_dat_oe_nx = r_dat_oe;
    w_done_nx   = 1'b0;
    w_error_nx  = 1'b0;
    w_abort     = 1'b0;
    w_timeout   = (r_cnt >= TO_LIM);
    w_bit_inc   = (r_bit == 4'hF) ? r_bit : r_bit + 4'd1;

    unique case (r_state)
      IDLE: begin
        w_clk_oe_nx = 1'b0;
        w_dat_oe_nx = 1'b0;
        w_bit_nx    = '0;
        w_cnt_nx    = '0;
        if (tx_valid) begin
          w_state_nx  = INHIBIT;
          w_data_nx   = tx_data;
          w_par_nx    = ps2_odd_parity(tx_data);
          w_cnt_nx    = CNT_ONE;
          w_clk_oe_nx = 1'b1;
          w_dat_oe_nx = (INHIBIT_CYCLES <= 1);
        end
      end

      // Counter holds the index of the current inhibit cycle (1-based), so the
      // start bit overlaps the last clock-low cycle by exactly one cycle.
      INHIBIT: begin
        w_cnt_nx = r_cnt + CNT_ONE;
        if (r_cnt >= INH_DAT) begin
          w_dat_oe_nx = 1'b1;
        end
        if (r_cnt >= INH_LAST) begin
          w_state_nx  = SHIFT;
          w_clk_oe_nx = 1'b0;
          w_cnt_nx    = CNT_ONE;
          w_bit_nx    = '0;
        end
      end

      // r_data is consumed LSB-first by shifting right on each data edge.
      SHIFT: begin
        if (w_clk_fall) begin
          w_cnt_nx = CNT_ONE;
          w_bit_nx = w_bit_inc;
          if (w_bit_inc <= 4'd8) begin
            w_dat_oe_nx = ~r_data[0];
            w_data_nx   = {1'b0, r_data[7:1]};
          end else if (w_bit_inc == 4'd9) begin
            w_dat_oe_nx = ~r_par;
          end else begin
            w_dat_oe_nx = 1'b0;
            w_state_nx  = ACK;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end

      ACK: begin
        if (w_clk_fall) begin
          if (!w_dat_sync) begin
            w_state_nx = WAIT_IDLE;
            w_cnt_nx   = CNT_ONE;
          end else begin
            w_abort = 1'b1;
          end
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end

      WAIT_IDLE: begin
        if (w_clk_sync && w_dat_sync) begin
          w_state_nx = IDLE;
          w_done_nx  = 1'b1;
          w_cnt_nx   = '0;
        end else if (w_clk_fall) begin
          w_cnt_nx = CNT_ONE;
        end else if (w_timeout) begin
          w_abort = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nx  = IDLE;
        w_clk_oe_nx = 1'b0;
        w_dat_oe_nx = 1'b0;
      end
    endcase

    if (w_abort) begin
      w_state_nx  = IDLE;
      w_clk_oe_nx = 1'b0;
      w_dat_oe_nx = 1'b0;
      w_cnt_nx    = '0;
      w_error_nx  = 1'b1;
    end
  end

  assign tx_ready   = (r_state == IDLE);
  assign tx_busy    = (r_state != IDLE);
  assign tx_done    = r_done;
  assign tx_error   = r_error;
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a device BFM clocks frames out of the
// host and every received frame is compared with a frame built from the byte.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 8;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       bfm_clk_low = 1'b0;
  logic       bfm_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | bfm_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | bfm_dat_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Bus monitor, sampled on the inactive clock edge.
  int cyc = 0, n_done = 0, n_err = 0, n_both = 0, n_bad_rel = 0;
  int clk_run = 0, last_clk_run = 0, t_clkoe_fall = 0, t_err = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) n_done <= n_done + 1;
    if (tx_error) begin
      n_err <= n_err + 1;
      t_err <= cyc;
      if (ps2_clk_oe || ps2_dat_oe) n_bad_rel <= n_bad_rel + 1;
    end
    if (tx_done && tx_error) n_both <= n_both + 1;
    if (ps2_clk_oe) clk_run <= clk_run + 1;
    else if (clk_run != 0) begin
      last_clk_run <= clk_run;
      clk_run      <= 0;
      t_clkoe_fall <= cyc;
    end
  end

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         poke;
    bit         exp_par;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line levels the device should see: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
  endfunction

  task automatic request(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Device BFM. stop_after>0 returns holding clk low in that clock's low phase.
  task automatic bfm(input int stop_after, input bit ack, input int poke,
                     output logic [10:0] fr, output bit ok);
    int w;
    ok = 1'b1;
    fr = '1;
    w = 0;
    while (!ps2_clk_oe && w < 100) begin tick(1); w++; end
    if (w >= 100) begin ok = 1'b0; return; end
    w = 0;
    while (ps2_clk_oe && w < 1000) begin tick(1); w++; end
    if (w >= 1000) begin ok = 1'b0; return; end
    tick(5);
    fr[0] = ps2_dat_in;
    for (int k = 1; k <= 10; k++) begin
      bfm_clk_low = 1'b1;
      if (k == stop_after) begin
        tick(HALF / 2);
        return;
      end
      tick(HALF);
      bfm_clk_low = 1'b0;
      fr[k] = ps2_dat_in;
      if (poke == k) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
      end
      tick(HALF);
      if (poke == k) tx_valid = 1'b0;
    end
    if (ack) bfm_dat_low = 1'b1;
    tick(HALF / 2);
    bfm_clk_low = 1'b1;
    tick(HALF);
    bfm_clk_low = 1'b0;
    tick(2);
    bfm_dat_low = 1'b0;
    tick(HALF);
  endtask

  task automatic do_xfer(input vec_t v, input bit chk_par);
    logic [10:0] fr;
    bit          ok;
    int          bd, be;
    bd = n_done;
    be = n_err;
    chk($sformatf("ready_before_%02h", v.data), int'(tx_ready), 1);
    request(v.data);
    chk($sformatf("busy_after_accept_%02h", v.data), int'(tx_busy), 1);
    bfm(0, v.ack, v.poke, fr, ok);
    chk($sformatf("bfm_sync_%02h", v.data), int'(ok), 1);
    for (int w = 0; w < 400 && (n_done + n_err) == (bd + be); w++) tick(1);
    tick(2);
    chk($sformatf("frame_%02h", v.data), int'(fr), int'(model_frame(v.data)));
    if (chk_par) chk($sformatf("parity_%02h", v.data), int'(fr[9]), int'(v.exp_par));
    chk($sformatf("inhibit_len_%02h", v.data), last_clk_run, INH);
    chk($sformatf("done_cnt_%02h", v.data), n_done - bd, v.ack ? 1 : 0);
    chk($sformatf("err_cnt_%02h", v.data), n_err - be, v.ack ? 0 : 1);
    chk($sformatf("lines_idle_%02h", v.data), int'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk($sformatf("ready_idle_%02h", v.data), int'({tx_ready, tx_busy}), 2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "bench stopped");
  end

  initial begin
    logic [10:0] fr;
    bit          ok;
    int          bd, be;
    vec_t        rv;

    tbl[0] = '{PS2_CMD_SET_LED, 1'b1, 0, 1'b1};
    tbl[1] = '{8'h00,           1'b1, 0, 1'b1};
    tbl[2] = '{8'hFF,           1'b1, 0, 1'b1};
    tbl[3] = '{8'h01,           1'b1, 0, 1'b0};
    tbl[4] = '{8'h03,           1'b1, 0, 1'b1};
    tbl[5] = '{PS2_CMD_ENABLE,  1'b1, 4, 1'b0};
    tbl[6] = '{PS2_CMD_RESET,   1'b1, 0, 1'b1};
    tbl[7] = '{PS2_CMD_ENABLE,  1'b0, 0, 1'b0};

    tick(5);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_pulses", int'({tx_done, tx_error}), 0);
    chk("reset_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    reset = 1'b0;
    tick(5);

    foreach (tbl[i]) do_xfer(tbl[i], 1'b1);

    // Device never clocks after the inhibit.
    bd = n_done;
    be = n_err;
    request(PS2_CMD_RESET);
    for (int w = 0; w < 2000 && n_err == be; w++) tick(1);
    tick(2);
    chk("timeout_err_cnt", n_err - be, 1);
    chk("timeout_done_cnt", n_done - bd, 0);
    chk("timeout_latency", t_err - t_clkoe_fall, TO);
    chk("timeout_inhibit_len", last_clk_run, INH);
    chk("timeout_lines", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("timeout_ready", int'(tx_ready), 1);

    // Reset while data bit 4 of 0xED (a zero) is on the line.
    bd = n_done;
    be = n_err;
    request(PS2_CMD_SET_LED);
    bfm(5, 1'b1, 0, fr, ok);
    chk("midrst_bfm_sync", int'(ok), 1);
    chk("midrst_busy_before", int'(tx_busy), 1);
    chk("midrst_dat_before", int'(ps2_dat_oe), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_oe", int'({ps2_clk_oe, ps2_dat_oe}), 0);
    chk("midrst_busy", int'(tx_busy), 0);
    chk("midrst_ready", int'(tx_ready), 1);
    bfm_clk_low = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(50);
    chk("midrst_no_pulse", (n_done - bd) + (n_err - be), 0);
    do_xfer(tbl[0], 1'b1);

    for (int r = 0; r < 6; r++) begin
      rv.data    = 8'($urandom_range(0, 255));
      rv.ack     = ($urandom_range(0, 3) != 0);
      rv.poke    = 0;
      rv.exp_par = 1'b0;
      do_xfer(rv, 1'b0);
    end

    chk("never_done_and_error", n_both, 0);
    chk("error_releases_lines", n_bad_rel, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
